// File: rtl/rop_perf_pkg.sv
// Shared types and widths for the ROP performance-counter producer.
// The per-cycle event bundle is assembled once and consumed by the counter bank.
package rop_perf_pkg;

    localparam int ROP_PERF_CTR_BITS = 44;
    // The lane count field is wide enough for any practical lane count.
    localparam int ROP_LANE_CNT_BITS = 8;

    typedef struct packed {
        logic                         rd_fire;
        logic                         wr_fire;
        logic                         rsp_fire;
        logic                         stall;
        logic [ROP_LANE_CNT_BITS-1:0] lane_cnt;
    } rop_perf_evt_t;

endpackage

// File: rtl/rop_perf_popcount.sv
// Combinational population count of a lane mask.
module rop_perf_popcount #(
    parameter  int N  = 4,
    localparam int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]  mask,
    output logic [CW-1:0] cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + CW'(mask[i]);
        end
    end

endmodule

// File: rtl/rop_perf_counter.sv
// Observes ROP memory and input-stage handshakes and accumulates read/write lanes,
// read latency (outstanding reads summed per cycle) and input stall cycles.
module rop_perf_counter
    import rop_perf_pkg::*;
#(
    parameter int NUM_LANES     = 4,
    parameter int MAX_PENDING   = 16,
    parameter int PERF_CTR_BITS = ROP_PERF_CTR_BITS
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     perf_enable,
    input  logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    input  logic                     mem_req_rw,
    input  logic [NUM_LANES-1:0]     mem_req_mask,
    input  logic                     mem_rsp_valid,
    input  logic                     mem_rsp_ready,
    input  logic                     in_valid,
    input  logic                     in_ready,
    output logic [PERF_CTR_BITS-1:0] mem_reads,
    output logic [PERF_CTR_BITS-1:0] mem_writes,
    output logic [PERF_CTR_BITS-1:0] mem_latency,
    output logic [PERF_CTR_BITS-1:0] stall_cycles,
    output logic                     perf_error
);

    localparam int CNT_W  = $clog2(NUM_LANES + 1);
    localparam int PEND_W = $clog2(MAX_PENDING + 1);

    logic [CNT_W-1:0]         lane_pop;
    rop_perf_evt_t            evt;
    logic                     req_fire;
    logic [PEND_W-1:0]        pending_reg, pending_next;
    logic                     err_set;
    logic                     perf_error_reg;
    logic [PERF_CTR_BITS-1:0] mem_reads_reg, mem_writes_reg, mem_latency_reg, stall_cycles_reg;

    rop_perf_popcount #(.N(NUM_LANES)) u_popcount (
        .mask (mem_req_mask),
        .cnt  (lane_pop)
    );

    // Zero-mask requests carry no lanes and are treated as if they never happened.
    assign req_fire = mem_req_valid && mem_req_ready && (mem_req_mask != '0);

    always_comb begin
        evt          = '0;
        evt.rd_fire  = req_fire && !mem_req_rw;
        evt.wr_fire  = req_fire && mem_req_rw;
        evt.rsp_fire = mem_rsp_valid && mem_rsp_ready;
        evt.stall    = in_valid && !in_ready;
        evt.lane_cnt = ROP_LANE_CNT_BITS'(lane_pop);
    end

    always_comb begin
        pending_next = pending_reg;
        err_set      = 1'b0;
        if (evt.rd_fire && !evt.rsp_fire) begin
            if (pending_reg == PEND_W'(MAX_PENDING)) begin
                err_set = 1'b1;
            end else begin
                pending_next = pending_reg + PEND_W'(1);
            end
        end else if (!evt.rd_fire && evt.rsp_fire) begin
            if (pending_reg == '0) begin
                err_set = 1'b1;
            end else begin
                pending_next = pending_reg - PEND_W'(1);
            end
        end
    end

    // Pending tracking and the error flag run regardless of perf_enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_reg    <= '0;
            perf_error_reg <= 1'b0;
        end else begin
            pending_reg    <= pending_next;
            perf_error_reg <= perf_error_reg | err_set;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_reads_reg    <= '0;
            mem_writes_reg   <= '0;
            mem_latency_reg  <= '0;
            stall_cycles_reg <= '0;
        end else if (perf_enable) begin
            if (evt.rd_fire) begin
                mem_reads_reg <= mem_reads_reg + PERF_CTR_BITS'(evt.lane_cnt);
            end
            if (evt.wr_fire) begin
                mem_writes_reg <= mem_writes_reg + PERF_CTR_BITS'(evt.lane_cnt);
            end
            if (evt.stall) begin
                stall_cycles_reg <= stall_cycles_reg + PERF_CTR_BITS'(1);
            end
            mem_latency_reg <= mem_latency_reg + PERF_CTR_BITS'(pending_reg);
        end
    end

    assign mem_reads    = mem_reads_reg;
    assign mem_writes   = mem_writes_reg;
    assign mem_latency  = mem_latency_reg;
    assign stall_cycles = stall_cycles_reg;
    assign perf_error   = perf_error_reg;

endmodule

// File: doc/rop_perf_counter.md
Name: rop_perf_counter

Overview:
- Producer (master side) of the ROP performance-counter bundle: mem_reads, mem_writes, mem_latency, stall_cycles.
- Snoops the ROP unit's memory request/response handshakes and its input-stage handshake.
- Accumulates the four counters that the CSR/perf aggregation logic reads.
- Sits beside the ROP memory unit; purely observational, never back-pressures anything.

Parameters:
- NUM_LANES, 4: lanes per ROP memory request; width of the request mask.
- MAX_PENDING, 16: maximum outstanding read transactions tracked.
- PERF_CTR_BITS, 44: width of every counter output (matches the PERF_CTR_BITS define).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- perf_enable  in  1  counters accumulate only while high.
- mem_req_valid  in  1  ROP memory request valid.
- mem_req_ready  in  1  ROP memory request ready.
- mem_req_rw  in  1  1 = write, 0 = read.
- mem_req_mask  in  NUM_LANES  active lanes of the request.
- mem_rsp_valid  in  1  read response valid (one response per read transaction).
- mem_rsp_ready  in  1  read response ready.
- in_valid  in  1  ROP input-stage valid.
- in_ready  in  1  ROP input-stage ready.
- mem_reads  out  PERF_CTR_BITS  read lanes issued.
- mem_writes  out  PERF_CTR_BITS  write lanes issued.
- mem_latency  out  PERF_CTR_BITS  sum over cycles of outstanding read transactions.
- stall_cycles  out  PERF_CTR_BITS  cycles with in_valid && !in_ready.
- perf_error  out  1  sticky: pending overflow or response with nothing pending.

Behaviour:
- Events:
  - req_fire = mem_req_valid && mem_req_ready && (mem_req_mask != 0); zero-mask requests are ignored entirely.
  - rd_fire = req_fire && !mem_req_rw.
  - wr_fire = req_fire && mem_req_rw.
  - rsp_fire = mem_rsp_valid && mem_rsp_ready.
- Counters:
  - mem_reads += popcount(mask) when rd_fire.
  - mem_writes += popcount(mask) when wr_fire.
  - stall_cycles += 1 when in_valid && !in_ready.
  - mem_latency += pending each cycle, where pending is the register value at the start of the cycle.
  - A read fired in cycle t therefore contributes from cycle t+1. Its response cycle is included, so a read issued at t0 and answered at t0+L adds exactly L.
- All outputs are registered. An event in cycle t is visible after the rising edge ending cycle t (1-cycle latency).
- Counters wrap modulo 2^PERF_CTR_BITS; there is no saturation.
- Pending register, width $clog2(MAX_PENDING+1):
  - Updated regardless of perf_enable, so tracking stays coherent across enable toggles.
  - rd_fire && rsp_fire in the same cycle: pending unchanged.
  - rd_fire only: +1. If pending == MAX_PENDING, hold and set perf_error.
  - rsp_fire only: -1. If pending == 0, hold at 0 and set perf_error.
- perf_enable low: all four counters hold their values; perf_error still updates.
- Reset:
  - reset_n low asynchronously clears all counters, pending and perf_error to 0.
  - Reset mid-operation discards outstanding reads; later responses for them set perf_error.
- No handshake outputs; the block never affects ready/valid.

Decomposition:
- VX_rop_define.vh / rop package:
  - PERF_CTR_BITS.
  - rop_perf_evt_t struct {rd_fire, wr_fire, rsp_fire, stall, lane_cnt}.
- Sub-module: rop_perf_popcount (NUM_LANES → $clog2(NUM_LANES+1) bits), combinational; the existing shared popcount may be reused.
- The counter bank stays in the top module; the master modport of the perf interface is driven from the outputs.

Test Plan:
- Reset then idle 10 cycles → all counters 0, perf_error 0.
- Read mask 4'b1011 at cycle 5, response at cycle 12 → mem_reads=3, mem_latency=7, pending returns to 0.
- Two reads at cycles 0 and 1, responses at cycles 4 and 4+1 → mem_latency=4+4=8; a read and a response in the same cycle leave pending unchanged.
- Write mask 4'b1111 ×3 plus in_valid=1/in_ready=0 for 6 cycles → mem_writes=12, stall_cycles=6, mem_reads=0.
- perf_enable=0 during 5 stall cycles and one read → counters unchanged; re-enable then respond → latency counts only enabled cycles, perf_error 0.
- Response with pending=0, and 17 reads with MAX_PENDING=16 → perf_error=1 and sticky, pending clamps at 0 and 16 respectively; reset_n pulse mid-run → everything 0 immediately.
